// File: rtl/pipe_stage_skid_if.sv
// Valid/ready channel carrying a payload plus a control bundle between pipeline stages.
// Latency: none (wires only).
// Backpressure: the consumer drives ready; the producer holds valid/data/ctrl until ready.
interface pipe_stage_skid_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 16
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with an optional 2-entry skid buffer and a synchronous flush.
// Latency: 1 cycle from in_fire to out_valid; one entry per cycle under continuous out_ready.
// Backpressure: SKID=1 gives a registered in_ready (state != FULL); SKID=0 gives ~out_valid | out_ready.
module pipe_stage_skid #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    CTRL_WIDTH = 16,
    parameter logic [CTRL_WIDTH-1:0] CTRL_NOP   = '0,
    parameter bit                    SKID       = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    pipe_stage_skid_if.slave    in_if,
    pipe_stage_skid_if.master   out_if,
    output logic [1:0]          occupancy
);
    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic [CTRL_WIDTH-1:0] r_main_ctrl;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [CTRL_WIDTH-1:0] r_skid_ctrl;

    logic w_in_ready;
    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: if (w_in_fire) w_next = ST_HALF;
                ST_HALF: begin
                    if (w_in_fire && !w_out_fire)      w_next = SKID ? ST_FULL : ST_HALF;
                    else if (!w_in_fire && w_out_fire) w_next = ST_EMPTY;
                end
                ST_FULL:  if (w_out_fire) w_next = ST_HALF;
                default:  w_next = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_out_valid      = (r_state != ST_EMPTY);
        w_in_ready       = SKID ? (r_state != ST_FULL) : (!w_out_valid || out_if.ready);
        w_in_fire        = in_if.valid && w_in_ready;
        w_out_fire       = w_out_valid && out_if.ready;
        w_load_main_in   = !flush && w_in_fire &&
                           ((r_state == ST_EMPTY) || ((r_state == ST_HALF) && w_out_fire));
        w_load_skid      = !flush && w_in_fire && !w_out_fire && (r_state == ST_HALF);
        w_load_main_skid = !flush && w_out_fire && (r_state == ST_FULL);
    end

    // Payload is never cleared on flush; only the control field is masked while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data <= '0;
            r_main_ctrl <= CTRL_NOP;
            r_skid_data <= '0;
            r_skid_ctrl <= CTRL_NOP;
        end else begin
            if (w_load_main_in) begin
                r_main_data <= in_if.data;
                r_main_ctrl <= in_if.ctrl;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= in_if.data;
                r_skid_ctrl <= in_if.ctrl;
            end
        end
    end

    assign in_if.ready  = w_in_ready;
    assign out_if.valid = w_out_valid;
    assign out_if.data  = r_main_data;
    assign out_if.ctrl  = w_out_valid ? r_main_ctrl : CTRL_NOP;
    assign occupancy    = r_state;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: SKID=1 and SKID=0 instances share stimulus, each tracked by a queue model.
module tb_pipe_stage_skid;
    localparam int             DW  = 32;
    localparam int             CW  = 16;
    localparam logic [CW-1:0]  NOP = 16'h5A5A;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic [1:0]    occ1;
    logic [1:0]    occ0;

    always #5 clk = ~clk;

    pipe_stage_skid_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) in1 ();
    pipe_stage_skid_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) out1 ();
    pipe_stage_skid_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) in0 ();
    pipe_stage_skid_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) out0 ();

    assign in1.valid  = in_valid;
    assign in1.data   = in_data;
    assign in1.ctrl   = in_ctrl;
    assign out1.ready = out_ready;
    assign in0.valid  = in_valid;
    assign in0.data   = in_data;
    assign in0.ctrl   = in_ctrl;
    assign out0.ready = out_ready;

    pipe_stage_skid #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CTRL_NOP(NOP), .SKID(1'b1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_if(in1), .out_if(out1), .occupancy(occ1));

    pipe_stage_skid #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CTRL_NOP(NOP), .SKID(1'b0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_if(in0), .out_if(out0), .occupancy(occ0));

    // Each model is an ordered queue of {ctrl, data} with capacity 2 (SKID=1) or 1 (SKID=0).
    logic [CW+DW-1:0] q1[$];
    logic [CW+DW-1:0] q0[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_rdy(input int sz, input bit skid);
        return skid ? (sz < 2) : (sz == 0 || out_ready);
    endfunction

    task automatic check_dut(input string tag, input bit skid, input int sz,
                             input logic [CW+DW-1:0] head, input logic v, input logic r,
                             input logic [1:0] occ, input logic [DW-1:0] d, input logic [CW-1:0] c);
        chk({tag, ".out_valid"}, 64'(v), 64'(sz > 0));
        chk({tag, ".in_ready"},  64'(r), 64'(m_rdy(sz, skid)));
        chk({tag, ".occupancy"}, 64'(occ), 64'(sz));
        chk({tag, ".out_ctrl"},  64'(c), (sz > 0) ? 64'(head[CW+DW-1:DW]) : 64'(NOP));
        if (sz > 0) chk({tag, ".out_data"}, 64'(d), 64'(head[DW-1:0]));
    endtask

    task automatic check_all();
        logic [CW+DW-1:0] h1;
        logic [CW+DW-1:0] h0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        h0 = (q0.size() > 0) ? q0[0] : '0;
        check_dut("s1", 1'b1, q1.size(), h1, out1.valid, in1.ready, occ1, out1.data, out1.ctrl);
        check_dut("s0", 1'b0, q0.size(), h0, out0.valid, in0.ready, occ0, out0.data, out0.ctrl);
    endtask

    task automatic model_edge();
        bit r1;
        bit r0;
        bit of1;
        bit of0;
        r1  = m_rdy(q1.size(), 1'b1);
        r0  = m_rdy(q0.size(), 1'b0);
        of1 = (q1.size() > 0) && out_ready;
        of0 = (q0.size() > 0) && out_ready;
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (of1) void'(q1.pop_front());
            if (of0) void'(q0.pop_front());
            if (in_valid && r1) q1.push_back({in_ctrl, in_data});
            if (in_valid && r0) q0.push_back({in_ctrl, in_data});
        end
    endtask

    // Compare on the falling edge, advance the model on the rising edge, return just after it.
    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst.s1.out_valid", 64'(out1.valid), 64'd0);
        chk("rst.s1.occupancy", 64'(occ1), 64'd0);
        chk("rst.s1.in_ready",  64'(in1.ready), 64'd1);
        chk("rst.s1.out_ctrl",  64'(out1.ctrl), 64'(NOP));
        chk("rst.s1.out_data",  64'(out1.data), 64'd0);
        chk("rst.s0.out_valid", 64'(out0.valid), 64'd0);
        chk("rst.s0.in_ready",  64'(in0.ready), 64'd1);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming with continuous out_ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'(32'h10 + i);
            in_ctrl = 16'($urandom);
            tick();
            chk("stream.s1.out_data", 64'(out1.data), 64'(32'h10 + i));
            chk("stream.s1.occupancy", 64'(occ1), 64'd1);
            chk("stream.s0.out_data", 64'(out0.data), 64'(32'h10 + i));
        end
        in_valid = 1'b0;
        tick();

        // Backpressure fills the skid entry.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA0;
        tick();
        in_data = 32'hA1;
        tick();
        in_valid = 1'b0;
        chk("bp.s1.occupancy", 64'(occ1), 64'd2);
        chk("bp.s1.in_ready",  64'(in1.ready), 64'd0);
        chk("bp.s1.out_data",  64'(out1.data), 64'hA0);
        chk("bp.s0.in_ready",  64'(in0.ready), 64'd0);
        chk("bp.s0.out_data",  64'(out0.data), 64'hA0);
        out_ready = 1'b1;
        #1;
        chk("bp.s0.in_ready_comb", 64'(in0.ready), 64'd1);
        tick();
        chk("bp.s1.second", 64'(out1.data), 64'hA1);
        chk("bp.s1.in_ready_after_pop", 64'(in1.ready), 64'd1);
        tick();
        chk("bp.s1.drained", 64'(out1.valid), 64'd0);

        // SKID=0 replace-in-place when out_ready rises.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hC0;
        tick();
        in_data = 32'hC1;
        #1;
        chk("s0.stall.in_ready", 64'(in0.ready), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("s0.unstall.in_ready", 64'(in0.ready), 64'd1);
        tick();
        chk("s0.replace.out_data", 64'(out0.data), 64'hC1);
        in_valid = 1'b0;
        tick();

        // Flush with a concurrent push.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hD0;
        tick();
        in_data = 32'hD1;
        tick();
        flush   = 1'b1;
        in_data = 32'hB0;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.s1.out_valid", 64'(out1.valid), 64'd0);
        chk("flush.s1.occupancy", 64'(occ1), 64'd0);
        chk("flush.s1.out_ctrl",  64'(out1.ctrl), 64'(NOP));
        chk("flush.s1.in_ready",  64'(in1.ready), 64'd1);
        chk("flush.s0.out_valid", 64'(out0.valid), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("flush.s1.no_b0", 64'(out1.valid), 64'd0);

        // Asynchronous reset mid-cycle with two entries held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hE0;
        tick();
        in_data = 32'hE1;
        tick();
        in_valid = 1'b0;
        chk("arst.pre.occupancy", 64'(occ1), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        q1.delete();
        q0.delete();
        chk("arst.s1.out_valid", 64'(out1.valid), 64'd0);
        chk("arst.s1.occupancy", 64'(occ1), 64'd0);
        chk("arst.s1.in_ready",  64'(in1.ready), 64'd1);
        chk("arst.s1.out_ctrl",  64'(out1.ctrl), 64'(NOP));
        chk("arst.s0.out_valid", 64'(out0.valid), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            flush     = ($urandom_range(31) == 0);
            in_data   = $urandom;
            in_ctrl   = 16'($urandom);
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
